// File: rtl/sc_game_sequencer.sv
// sc_game_sequencer: Frogger game sequencer owning level/lives, the level-dependent
// lane shift tick and the lane clear/load strobes.
module sc_game_sequencer #(
    parameter int LIVES_INIT   = 3,
    parameter int NUM_LEVELS   = 4,
    parameter int LVL_W        = 2,
    parameter int BASE_PERIOD  = 25000000,
    parameter int PERIOD_STEP  = 5000000,
    parameter int MIN_PERIOD   = 2500000,
    parameter int PAUSE_CYCLES = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic             SC_GAMESEQ_CLOCK_50,
    input  logic             SC_GAMESEQ_RESET_InLow,
    input  logic             SC_GAMESEQ_startButton_InLow,
    input  logic             SC_GAMESEQ_collision_InLow,
    input  logic             SC_GAMESEQ_goal_InLow,
    output logic             SC_GAMESEQ_clear_OutLow,
    output logic             SC_GAMESEQ_load_OutLow,
    output logic             SC_GAMESEQ_shiftTick_Out,
    output logic [LVL_W-1:0] SC_GAMESEQ_level_Out,
    output logic [2:0]       SC_GAMESEQ_lives_Out,
    output logic             SC_GAMESEQ_playing_Out,
    output logic             SC_GAMESEQ_gameOver_Out,
    output logic             SC_GAMESEQ_win_Out
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        PLAY      = 3'd2,
        HIT       = 3'd3,
        LEVEL_UP  = 3'd4,
        GAME_OVER = 3'd5,
        WIN       = 3'd6
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] presc, pause, period_m1;
    logic [31:0]      step_total, period;
    logic [LVL_W-1:0] level;
    logic [2:0]       lives;
    logic             start_prev, press, tick, pause_end, presc_end;

    always_comb begin
        step_total = 32'(level) * 32'(PERIOD_STEP);
        period     = (step_total >= 32'(BASE_PERIOD - MIN_PERIOD)) ? 32'(MIN_PERIOD)
                                                                    : 32'(BASE_PERIOD) - step_total;
        period_m1  = CNT_W'(period - 32'd1);
        press      = start_prev & ~SC_GAMESEQ_startButton_InLow;
        pause_end  = pause == CNT_W'(PAUSE_CYCLES - 1);
        presc_end  = presc == period_m1;
    end

    // The tick is registered, so it appears P cycles after PLAY entry and never leaks out of PLAY.
    always_ff @(posedge SC_GAMESEQ_CLOCK_50) begin
        if (!SC_GAMESEQ_RESET_InLow) begin
            state      <= IDLE;
            lives      <= 3'(LIVES_INIT);
            level      <= '0;
            presc      <= '0;
            pause      <= '0;
            start_prev <= 1'b1;
            tick       <= 1'b0;
        end else begin
            start_prev <= SC_GAMESEQ_startButton_InLow;
            tick       <= 1'b0;
            case (state)
                IDLE: if (press) state <= LOAD;
                LOAD: begin
                    presc <= '0;
                    state <= PLAY;
                end
                PLAY: begin
                    if (!SC_GAMESEQ_collision_InLow) begin
                        state <= HIT;
                        pause <= '0;
                        lives <= (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                    end else if (!SC_GAMESEQ_goal_InLow) begin
                        state <= LEVEL_UP;
                        pause <= '0;
                    end else begin
                        presc <= presc_end ? '0 : presc + 1'b1;
                        tick  <= presc_end;
                    end
                end
                HIT: begin
                    if (pause_end) state <= (lives == 3'd0) ? GAME_OVER : LOAD;
                    else pause <= pause + 1'b1;
                end
                LEVEL_UP: begin
                    if (!pause_end) pause <= pause + 1'b1;
                    else if (level == LVL_W'(NUM_LEVELS - 1)) state <= WIN;
                    else begin
                        level <= level + 1'b1;
                        state <= LOAD;
                    end
                end
                GAME_OVER, WIN: begin
                    if (press) begin
                        lives <= 3'(LIVES_INIT);
                        level <= '0;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SC_GAMESEQ_clear_OutLow  = !(state == IDLE || state == GAME_OVER || state == WIN);
    assign SC_GAMESEQ_load_OutLow   = state != LOAD;
    assign SC_GAMESEQ_shiftTick_Out = tick;
    assign SC_GAMESEQ_level_Out     = level;
    assign SC_GAMESEQ_lives_Out     = lives;
    assign SC_GAMESEQ_playing_Out   = state == PLAY;
    assign SC_GAMESEQ_gameOver_Out  = state == GAME_OVER;
    assign SC_GAMESEQ_win_Out       = state == WIN;
endmodule
